systolic_feeder: RTL

Upstream operand stage for the 3x3 systolic array. Accepts one A matrix and one B matrix per job over a valid/ready handshake. Emits the diagonally skewed west (A) and north (B) lane streams with the array enable, then holds the enable until the array reports done. Marks job completion with a one-cycle pulse.

---
 rtl/systolic_feeder_pkg.sv | 15 +
 rtl/systolic_skew_lane.sv | 17 +
 rtl/systolic_feeder.sv | 117 +++++++++++
 3 files changed

// File: rtl/systolic_feeder_pkg.sv
// Shared constants, operand types and FSM encoding for the systolic feeder.
package systolic_pkg;
  localparam int N       = 3;
  localparam int DW      = 8;
  localparam int TIMEOUT = 64;
  localparam int STEPS   = 2*N - 1;
  localparam int TW      = $clog2(STEPS);
  localparam int LANE_W  = N*DW;
  localparam int MAT_W   = N*N*DW;

  typedef logic [N-1:0][DW-1:0]   vec_t;
  typedef logic [N*N-1:0][DW-1:0] mat_t;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT} state_t;
endpackage

// File: rtl/systolic_skew_lane.sv
// One skewed lane: presents element (t - LANE) of its row/column, else 0.
module systolic_skew_lane
  import systolic_pkg::*;
#(
  parameter int LANE = 0
) (
  input  vec_t            i_vec,
  input  logic [TW-1:0]   i_t,
  input  logic            i_en,
  output logic [DW-1:0]   o_elem
);
  always_comb begin
    o_elem = '0;
    for (int k = 0; k < N; k++)
      if (i_en && (int'(i_t) == LANE + k)) o_elem = i_vec[k];
  end
endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for the NxN systolic array: captures A/B, streams skewed lanes,
// holds enable until done. Optional WAIT timeout under SYSTOLIC_FEEDER_TIMEOUT_EN.
module systolic_feeder
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MAT_W-1:0]  a_mat,
  input  logic [MAT_W-1:0]  b_mat,
  output logic [LANE_W-1:0] a_w,
  output logic [LANE_W-1:0] b_n,
  output logic              arr_en,
  input  logic              arr_done,
  output logic              busy,
  output logic              job_done,
  output logic              err
);
  state_t              r_state, w_state_nxt;
  logic [TW-1:0]       r_t, w_t_nxt;
  mat_t                r_a, r_b, w_a_src, w_b_src;
  logic [N-1:0][DW-1:0] w_a_lane, w_b_lane, r_a_w, r_b_n;
  logic                r_arr_en, r_busy, r_job_done;
  logic                w_accept, w_done, w_tmo, w_lane_en;

  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid && in_ready;
  assign w_done   = (r_state == S_WAIT) && arr_done;

  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    case (r_state)
      S_IDLE:   if (w_accept) begin w_state_nxt = S_STREAM; w_t_nxt = '0; end
      S_STREAM: if (r_t == TW'(STEPS-1)) begin
                  w_state_nxt = S_WAIT;
                  w_t_nxt     = '0;
                end else w_t_nxt = r_t + 1'b1;
      S_WAIT:   if (w_done || w_tmo) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Lanes are computed from the next state/counter so the registered outputs
  // line up with the cycle that state is actually in.
  assign w_a_src   = w_accept ? a_mat : r_a;
  assign w_b_src   = w_accept ? b_mat : r_b;
  assign w_lane_en = (w_state_nxt == S_STREAM);

  for (genvar i = 0; i < N; i++) begin : g_lane
    vec_t w_row, w_col;
    for (genvar k = 0; k < N; k++) begin : g_el
      assign w_row[k] = w_a_src[i*N + k];
      assign w_col[k] = w_b_src[k*N + i];
    end
    systolic_skew_lane #(.LANE(i)) u_a (
      .i_vec(w_row), .i_t(w_t_nxt), .i_en(w_lane_en), .o_elem(w_a_lane[i]));
    systolic_skew_lane #(.LANE(i)) u_b (
      .i_vec(w_col), .i_t(w_t_nxt), .i_en(w_lane_en), .o_elem(w_b_lane[i]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_t        <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_a_w      <= '0;
      r_b_n      <= '0;
      r_arr_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_job_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_t        <= w_t_nxt;
      if (w_accept) begin
        r_a <= a_mat;
        r_b <= b_mat;
      end
      r_a_w      <= w_a_lane;
      r_b_n      <= w_b_lane;
      r_arr_en   <= (w_state_nxt != S_IDLE);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_job_done <= w_done;
    end
  end

`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT);
  logic [WCW-1:0] r_wcnt;
  logic           r_err;

  // Done on the final WAIT cycle still wins over the timeout.
  assign w_tmo = (r_state == S_WAIT) && !arr_done && (r_wcnt == WCW'(TIMEOUT-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wcnt <= (r_state == S_WAIT) ? r_wcnt + 1'b1 : '0;
      r_err  <= r_err | w_tmo;
    end
  end
  assign err = r_err;
`else
  assign w_tmo = 1'b0;
  assign err   = 1'b0;
`endif

  assign a_w      = r_a_w;
  assign b_n      = r_b_n;
  assign arr_en   = r_arr_en;
  assign busy     = r_busy;
  assign job_done = r_job_done;
endmodule
